// File: rtl/freq_display_pkg.sv
// ============================================================================
// Module : freq_display_pkg
// Brief  : Shared constants, segment encoding and FSM states for freq_display.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package freq_display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned BIN_W      = 28;
  localparam int unsigned BCD_W      = 32;

  localparam logic [27:0] FREQ_MAX = 28'd99_999_999;
  localparam logic [6:0]  DUTY_MAX = 7'd100;

  // Active-low segment codes, bit 0 = segment a .. bit 6 = segment g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_encode = SEG_0;
      4'd1:    seg_encode = SEG_1;
      4'd2:    seg_encode = SEG_2;
      4'd3:    seg_encode = SEG_3;
      4'd4:    seg_encode = SEG_4;
      4'd5:    seg_encode = SEG_5;
      4'd6:    seg_encode = SEG_6;
      4'd7:    seg_encode = SEG_7;
      4'd8:    seg_encode = SEG_8;
      4'd9:    seg_encode = SEG_9;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module : bin2bcd_seq
// Brief  : Sequential double-dabble converter, 28-bit binary to 8 BCD digits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import freq_display_pkg::*;
(
  input  logic              clk_100M,
  input  logic              rst,
  input  logic              i_start,
  input  logic [BIN_W-1:0]  i_bin,
  output logic              o_idle,
  output logic              o_done,
  output logic [BCD_W-1:0]  o_bcd
);

  localparam int unsigned SR_W = BCD_W + BIN_W;
  localparam logic [4:0]  LAST_STEP = 5'(BIN_W - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [4:0]        r_step;
  logic [SR_W-1:0]   r_sr;
  logic [SR_W-1:0]   w_adj;

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_idle       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_idle = 1'b1;
        if (i_start) w_state_next = ST_CONV;
      end
      ST_CONV: if (r_step == LAST_STEP) w_state_next = ST_DONE;
      ST_DONE: begin
        o_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Correct every BCD nibble that would overflow past 9 once doubled
  always_comb begin
    w_adj = r_sr;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (r_sr[BIN_W + 4*i +: 4] >= 4'd5)
        w_adj[BIN_W + 4*i +: 4] = r_sr[BIN_W + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      r_sr   <= '0;
      r_step <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) r_sr <= {{BCD_W{1'b0}}, i_bin};
          r_step <= '0;
        end
        ST_CONV: begin
          r_sr   <= w_adj << 1;
          r_step <= r_step + 5'd1;
        end
        default: r_step <= '0;
      endcase
    end
  end

  assign o_bcd = r_sr[SR_W-1 -: BCD_W];

endmodule

`default_nettype wire

// File: rtl/freq_display.sv
// ============================================================================
// Module : freq_display
// Brief  : Samples frequency/duty, converts to BCD and scans an 8-digit
//          7-segment display. Define FREQ_DISPLAY_LZB_EN to blank leading zeros.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module freq_display
  import freq_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 10_000_000,
  parameter int unsigned SCAN_DIV    = 100_000
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic [27:0] freq,
  input  logic [6:0]  duty,
  input  logic        mode,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        ovf,
  output logic        upd
);

  localparam int unsigned REF_W  = $clog2(REFRESH_DIV);
  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [2:0]        DUTY_FIRST_BLANK = 3'd3;

  logic [REF_W-1:0]  r_ref_cnt;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [2:0]        r_idx;
  logic              w_tick;
  logic              w_start;
  logic              w_eng_idle;
  logic              w_eng_done;
  logic [BCD_W-1:0]  w_bcd;
  logic              w_freq_clip;
  logic              w_duty_clip;
  logic              w_clip;
  logic [BIN_W-1:0]  w_sel_bin;
  logic              r_cap_mode;
  logic              r_cap_clip;
  logic [BCD_W-1:0]  r_disp_bcd;
  logic              r_disp_mode;
  logic              r_ovf;
  logic              r_upd;
  logic [6:0]        r_seg;
  logic [7:0]        r_an;
  logic [3:0]        w_digit;
  logic [7:0]        w_lz;
  logic              w_blank;
  logic [6:0]        w_seg_next;

  assign w_tick = (r_ref_cnt == REF_LAST);

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst)        r_ref_cnt <= '0;
    else if (w_tick) r_ref_cnt <= '0;
    else             r_ref_cnt <= r_ref_cnt + 1'b1;
  end

  assign w_freq_clip = (freq > FREQ_MAX);
  assign w_duty_clip = (duty > DUTY_MAX);
  assign w_clip      = mode ? w_duty_clip : w_freq_clip;
  assign w_sel_bin   = mode ? {21'd0, (w_duty_clip ? DUTY_MAX : duty)}
                            : (w_freq_clip ? FREQ_MAX : freq);
  // Ticks while a conversion is in flight are dropped
  assign w_start     = w_tick & w_eng_idle;

  bin2bcd_seq u_bin2bcd (
    .clk_100M (clk_100M),
    .rst      (rst),
    .i_start  (w_start),
    .i_bin    (w_sel_bin),
    .o_idle   (w_eng_idle),
    .o_done   (w_eng_done),
    .o_bcd    (w_bcd)
  );

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      r_cap_mode  <= 1'b0;
      r_cap_clip  <= 1'b0;
      r_disp_bcd  <= '0;
      r_disp_mode <= 1'b0;
      r_ovf       <= 1'b0;
      r_upd       <= 1'b0;
    end else begin
      r_upd <= w_eng_done;
      if (w_start) begin
        r_cap_mode <= mode;
        r_cap_clip <= w_clip;
      end
      if (w_eng_done) begin
        r_disp_bcd  <= w_bcd;
        r_disp_mode <= r_cap_mode;
        r_ovf       <= r_cap_clip;
      end
    end
  end

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 3'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  assign w_digit = r_disp_bcd[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_lz = '0;
`ifdef FREQ_DISPLAY_LZB_EN
    w_lz[NUM_DIGITS-1] = (r_disp_bcd[BCD_W-1 -: 4] == 4'd0);
    for (int i = int'(NUM_DIGITS) - 2; i >= 1; i--)
      w_lz[i] = w_lz[i+1] & (r_disp_bcd[4*i +: 4] == 4'd0);
`endif
    w_blank    = w_lz[r_idx] | (r_disp_mode & (r_idx >= DUTY_FIRST_BLANK));
    w_seg_next = w_blank ? SEG_BLANK : seg_encode(w_digit);
  end

  // seg and an registered together so both switch on one edge
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      r_seg <= SEG_BLANK;
      r_an  <= 8'hFF;
    end else begin
      r_seg <= w_seg_next;
      r_an  <= ~(8'd1 << r_idx);
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign ovf = r_ovf;
  assign upd = r_upd;

endmodule

`default_nettype wire
